nes_cpu_bus_master: RTL and testbench
=====================================

Name: nes_cpu_bus_master

Overview:
- Console-side initiator for the NES CPU cartridge bus.
- Turns a simple request/response handshake into NES CPU bus cycles, one transaction per bus cycle.
- Drives m2, romsel, r/w, address and data; samples read data.
- Used by the mapper test harness and the dumper/programmer to write mapper registers (address-latched writes at $8000-$FFFF) and to read PRG/WRAM.

Parameters:
- LOW_CYCLES, 3, clk cycles per m2-low phase; minimum 2.
- HIGH_CYCLES, 3, clk cycles per m2-high phase; minimum 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid & req_ready at a rising clk edge.
- req_addr  input  16  full CPU address.
- req_rw  input  1  1 = read, 0 = write.
- req_wdata  input  8  write data.
- rsp_valid  output  1  one-clk pulse, transaction complete.
- rsp_rdata  output  8  read data; 0 for writes.
- m2  output  1  CPU phase-2 clock.
- romsel  output  1  active-low, = ~(A15 & m2).
- cpu_rw  output  1  1 = read, 0 = write.
- cpu_addr  output  15  A14..A0.
- cpu_data_out  output  8  write data.
- cpu_data_oe  output  1  data bus drive enable.
- cpu_data_in  input  8  read data from cartridge.

Behaviour:
- Reset (async, while rst_n=0):
  - m2=0, romsel=1, cpu_rw=1, cpu_addr=0, cpu_data_out=0, cpu_data_oe=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0.
  - Internal A15=0, phase=LOW, count=0.
- Reset mid-transaction aborts it silently; no rsp_valid is produced for it.
- Free-running m2:
  - m2 is low for LOW_CYCLES clks, then high for HIGH_CYCLES clks, repeating.
  - Counter width is $clog2(max(LOW_CYCLES,HIGH_CYCLES)).
  - m2 keeps running when idle.
  - A bus cycle runs from the first low clk to the last high clk.
- Acceptance:
  - req_ready=1 only during the last clk of the high phase; 0 otherwise and during reset.
  - On acceptance, req_addr, req_rw and req_wdata are captured into internal registers.
- Low-phase clk 0 (boundary):
  - m2 falls and romsel goes 1.
  - cpu_rw, cpu_addr and cpu_data_oe keep their previous-cycle values. This is hold time: the cartridge latches on the rising edge of romsel, so cpu_rw=0 and the address must be stable across it.
- Low-phase clk 1:
  - If a request was accepted: cpu_addr=addr[14:0], A15 = addr[15], cpu_rw=rw.
  - For writes: cpu_data_out=wdata, cpu_data_oe=1. For reads: cpu_data_oe=0.
  - If no request was accepted (idle cycle): cpu_rw=1, cpu_data_oe=0, address and A15 unchanged.
- High phase:
  - m2=1.
  - romsel = ~A15, registered and aligned with m2; it never glitches low in the low phase.
- Last high clk:
  - For the transaction of this cycle, rsp_valid=1 on the next clk edge.
  - rsp_rdata = cpu_data_in sampled on this edge for reads, 8'h00 for writes.
  - rsp_rdata holds until the next response.
- Throughput: back-to-back requests give one transaction per bus cycle with no idle cycle between them.
- Simultaneous response/acceptance: the rsp_valid of cycle N and the acceptance for cycle N+1 coincide on the same edge; both are honoured.
- Write followed by read: cpu_data_oe drops at low-phase clk 1 of the read cycle, the same edge where cpu_rw rises.
- A request held valid across reset is re-accepted at the first boundary after release.

Test Plan:
- Write $9234 data $00, default params:
  - low clk1: cpu_rw=0, cpu_addr=0x1234.
  - romsel low during the 3 high clks.
  - romsel rises on the clk where m2 falls, with cpu_rw still 0 and cpu_addr still 0x1234.
  - cpu_rw returns to 1 one clk later.
  - rsp_valid pulse with rsp_rdata=0.
- Read $6000 with cpu_data_in=0xA5:
  - romsel stays 1 throughout, cpu_rw=1, cpu_data_oe=0.
  - rsp_valid with rsp_rdata=0xA5.
- Three back-to-back writes ($8000, $C001, $FFFF) with req_valid held:
  - accepted on 3 consecutive cycle ends, exactly 6 clks apart.
  - 3 rsp_valid pulses 6 clks apart.
  - no idle cycle in between.
- req_valid low for 2 cycles:
  - m2 keeps toggling, cpu_rw=1, romsel=1, address held, no rsp_valid.
- Assert rst_n=0 mid-high-phase of a $8000 write:
  - outputs at reset values immediately (romsel=1, m2=0).
  - no rsp_valid.
  - a new request is served normally after release.
- LOW_CYCLES=2, HIGH_CYCLES=1:
  - bus period 3 clks.
  - write-then-read timing rules still hold: one-clk hold after the m2 fall, and cpu_data_oe releases with cpu_rw.

Source files
------------

// File: rtl/nes_cpu_bus_master.sv
// NES CPU cartridge-bus initiator: a free-running M2 clock with one
// request/response transaction carried per bus cycle.
module nes_cpu_bus_master #(
  parameter int LOW_CYCLES  = 3,
  parameter int HIGH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_rw,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in
);

  localparam int MAX_CYCLES = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0] LOW_LAST    = CW'(LOW_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LAST   = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_PENULT = CW'((HIGH_CYCLES > 1) ? HIGH_CYCLES - 2 : 0);

  typedef enum logic {PH_LOW, PH_HIGH} phase_t;

  phase_t          r_phase;
  logic [CW-1:0]   r_count;
  logic            r_a15;
  logic            r_active;
  logic            r_rw_q;
  logic [15:0]     r_addr_q;
  logic [7:0]      r_wdata_q;
  logic            r_ready;
  logic            r_rsp_valid;
  logic [7:0]      r_rsp_rdata;
  logic            r_m2;
  logic            r_romsel;
  logic            r_cpu_rw;
  logic [14:0]     r_cpu_addr;
  logic [7:0]      r_cpu_data_out;
  logic            r_cpu_data_oe;

  logic w_last_low;
  logic w_last_high;
  logic w_enter_low1;
  logic w_enter_last_high;
  logic w_accept;

  assign w_last_low   = (r_phase == PH_LOW)  && (r_count == LOW_LAST);
  assign w_last_high  = (r_phase == PH_HIGH) && (r_count == HIGH_LAST);
  assign w_enter_low1 = (r_phase == PH_LOW)  && (r_count == '0);
  // With a single high clk, the last-high clk is entered straight from the low phase.
  assign w_enter_last_high = (HIGH_CYCLES == 1) ? w_last_low
                           : ((r_phase == PH_HIGH) && (r_count == HIGH_PENULT));
  assign w_accept = req_valid & r_ready;

  // NOTE: all state below is sequential and uses non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase        <= PH_LOW;
      r_count        <= '0;
      r_a15          <= 1'b0;
      r_active       <= 1'b0;
      r_rw_q         <= 1'b1;
      r_addr_q       <= '0;
      r_wdata_q      <= '0;
      r_ready        <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= '0;
      r_m2           <= 1'b0;
      r_romsel       <= 1'b1;
      r_cpu_rw       <= 1'b1;
      r_cpu_addr     <= '0;
      r_cpu_data_out <= '0;
      r_cpu_data_oe  <= 1'b0;
    end else begin
      r_ready     <= w_enter_last_high;
      r_rsp_valid <= 1'b0;
      if (w_last_high) begin
        // Bus-cycle boundary: M2 falls, ROMSEL releases, rw/addr/oe are held one clk.
        r_phase  <= PH_LOW;
        r_count  <= '0;
        r_m2     <= 1'b0;
        r_romsel <= 1'b1;
        if (r_active) begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_rw_q ? cpu_data_in : 8'h00;
        end
        r_active <= w_accept;
        if (w_accept) begin
          r_addr_q  <= req_addr;
          r_rw_q    <= req_rw;
          r_wdata_q <= req_wdata;
        end
      end else if (w_last_low) begin
        r_phase  <= PH_HIGH;
        r_count  <= '0;
        r_m2     <= 1'b1;
        // Idle cycles keep ROMSEL deasserted even if the held address is in ROM space.
        r_romsel <= ~(r_a15 & r_active);
      end else begin
        r_count <= r_count + CW'(1);
        if (w_enter_low1) begin
          if (r_active) begin
            r_cpu_addr    <= r_addr_q[14:0];
            r_a15         <= r_addr_q[15];
            r_cpu_rw      <= r_rw_q;
            r_cpu_data_oe <= ~r_rw_q;
            if (!r_rw_q) begin
              r_cpu_data_out <= r_wdata_q;
            end
          end else begin
            r_cpu_rw      <= 1'b1;
            r_cpu_data_oe <= 1'b0;
          end
        end
      end
    end
  end

  assign req_ready    = r_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign m2           = r_m2;
  assign romsel       = r_romsel;
  assign cpu_rw       = r_cpu_rw;
  assign cpu_addr     = r_cpu_addr;
  assign cpu_data_out = r_cpu_data_out;
  assign cpu_data_oe  = r_cpu_data_oe;

endmodule

// File: tb/tb_nes_cpu_bus_master.sv
// Bench for nes_cpu_bus_master: default timing (unit 0) and LOW=2/HIGH=1 (unit 1),
// checked clk-by-clk against a bus-cycle-level reference model.
module tb_nes_cpu_bus_master;

  logic clk;
  logic rst_n;

  logic        req_valid   [2];
  logic        req_ready   [2];
  logic [15:0] req_addr    [2];
  logic        req_rw      [2];
  logic [7:0]  req_wdata   [2];
  logic        rsp_valid   [2];
  logic [7:0]  rsp_rdata   [2];
  logic        m2          [2];
  logic        romsel      [2];
  logic        cpu_rw      [2];
  logic [14:0] cpu_addr    [2];
  logic [7:0]  cpu_data_out[2];
  logic        cpu_data_oe [2];
  logic [7:0]  cpu_data_in [2];

  nes_cpu_bus_master u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_rw(req_rw[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .m2(m2[0]), .romsel(romsel[0]), .cpu_rw(cpu_rw[0]), .cpu_addr(cpu_addr[0]),
    .cpu_data_out(cpu_data_out[0]), .cpu_data_oe(cpu_data_oe[0]),
    .cpu_data_in(cpu_data_in[0])
  );

  nes_cpu_bus_master #(.LOW_CYCLES(2), .HIGH_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_rw(req_rw[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .m2(m2[1]), .romsel(romsel[1]), .cpu_rw(cpu_rw[1]), .cpu_addr(cpu_addr[1]),
    .cpu_data_out(cpu_data_out[1]), .cpu_data_oe(cpu_data_oe[1]),
    .cpu_data_in(cpu_data_in[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clks elapsed since reset release; bus position is this count modulo the period.
  int unsigned k;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  typedef struct {
    bit          v;
    bit          rw;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  din;
  } txn_t;

  txn_t        cur    [2];
  logic [14:0] e_addr [2];
  bit          e_a15  [2];
  bit          e_rw   [2];
  bit          e_oe   [2];
  logic [7:0]  e_dout [2];
  logic [7:0]  e_rdata[2];

  int checks;
  int errors;

  function automatic int low_of(input int u);
    return (u == 0) ? 3 : 2;
  endfunction

  function automatic int per_of(input int u);
    return (u == 0) ? 6 : 3;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int u);
    cur[u]     = '{v: 1'b0, rw: 1'b1, addr: 16'h0, wd: 8'h0, din: 8'h0};
    e_addr[u]  = '0;
    e_a15[u]   = 1'b0;
    e_rw[u]    = 1'b1;
    e_oe[u]    = 1'b0;
    e_dout[u]  = '0;
    e_rdata[u] = '0;
  endtask

  // Bus drive established on the second low clk of a cycle.
  task automatic model_drive(input int u);
    if (cur[u].v) begin
      e_addr[u] = cur[u].addr[14:0];
      e_a15[u]  = cur[u].addr[15];
      e_rw[u]   = cur[u].rw;
      e_oe[u]   = !cur[u].rw;
      if (!cur[u].rw) e_dout[u] = cur[u].wd;
    end else begin
      e_rw[u] = 1'b1;
      e_oe[u] = 1'b0;
    end
  endtask

  task automatic check_outputs(input int u, input int p, input bit rsp_exp);
    bit high;
    high = (p >= low_of(u));
    check($sformatf("u%0d p%0d m2", u, p), 16'(m2[u]), 16'(high));
    check($sformatf("u%0d p%0d romsel", u, p), 16'(romsel[u]),
          16'(high ? !(e_a15[u] && cur[u].v) : 1'b1));
    check($sformatf("u%0d p%0d cpu_rw", u, p), 16'(cpu_rw[u]), 16'(e_rw[u]));
    check($sformatf("u%0d p%0d cpu_addr", u, p), 16'(cpu_addr[u]), 16'(e_addr[u]));
    check($sformatf("u%0d p%0d data_oe", u, p), 16'(cpu_data_oe[u]), 16'(e_oe[u]));
    check($sformatf("u%0d p%0d data_out", u, p), 16'(cpu_data_out[u]), 16'(e_dout[u]));
    check($sformatf("u%0d p%0d req_ready", u, p), 16'(req_ready[u]), 16'(p == per_of(u) - 1));
    check($sformatf("u%0d p%0d rsp_valid", u, p), 16'(rsp_valid[u]), 16'(rsp_exp));
    check($sformatf("u%0d p%0d rsp_rdata", u, p), 16'(rsp_rdata[u]), 16'(e_rdata[u]));
  endtask

  task automatic check_reset(input int u);
    check($sformatf("u%0d rst m2", u), 16'(m2[u]), 16'h0);
    check($sformatf("u%0d rst romsel", u), 16'(romsel[u]), 16'h1);
    check($sformatf("u%0d rst cpu_rw", u), 16'(cpu_rw[u]), 16'h1);
    check($sformatf("u%0d rst cpu_addr", u), 16'(cpu_addr[u]), 16'h0);
    check($sformatf("u%0d rst data_out", u), 16'(cpu_data_out[u]), 16'h0);
    check($sformatf("u%0d rst data_oe", u), 16'(cpu_data_oe[u]), 16'h0);
    check($sformatf("u%0d rst req_ready", u), 16'(req_ready[u]), 16'h0);
    check($sformatf("u%0d rst rsp_valid", u), 16'(rsp_valid[u]), 16'h0);
    check($sformatf("u%0d rst rsp_rdata", u), 16'(rsp_rdata[u]), 16'h0);
  endtask

  // Walk an idle unit forward, checking each clk, until its last high clk.
  task automatic align(input int u);
    for (int n = 0; n < 20; n++) begin
      int p;
      p = int'(k % per_of(u));
      if (p == 1) model_drive(u);
      check_outputs(u, p, 1'b0);
      if (p == per_of(u) - 1) break;
      @(negedge clk);
    end
  endtask

  // Entered on the last high clk: present a request (or none) and run the next bus cycle.
  task automatic step(input int u, input bit v, input logic [15:0] addr, input bit rw,
                      input logic [7:0] wd, input logic [7:0] din);
    bit rsp_exp;
    req_valid[u] = v;
    req_addr[u]  = addr;
    req_rw[u]    = rw;
    req_wdata[u] = wd;
    @(negedge clk);
    rsp_exp = cur[u].v;
    if (cur[u].v) e_rdata[u] = cur[u].rw ? cur[u].din : 8'h00;
    cur[u] = '{v: v, rw: rw, addr: addr, wd: wd, din: din};
    check_outputs(u, 0, rsp_exp);
    cpu_data_in[u] = din;
    for (int p = 1; p < per_of(u); p++) begin
      @(negedge clk);
      if (p == 1) model_drive(u);
      check_outputs(u, p, 1'b0);
    end
  endtask

  task automatic random_steps(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      a = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       a = {1'b1, a[14:0]};
        1:       a = {3'b011, a[12:0]};
        default: ;
      endcase
      step(u, $urandom_range(0, 3) != 0, a, 1'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int u = 0; u < 2; u++) begin
      req_valid[u]   = 1'b0;
      req_addr[u]    = '0;
      req_rw[u]      = 1'b1;
      req_wdata[u]   = '0;
      cpu_data_in[u] = '0;
      model_reset(u);
    end
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;

    // Default timing: mapper write, WRAM read, back-to-back ROM writes, idle cycles.
    align(0);
    step(0, 1'b1, 16'h9234, 1'b0, 8'h00, 8'h00);
    step(0, 1'b1, 16'h6000, 1'b1, 8'h00, 8'hA5);
    step(0, 1'b1, 16'h8000, 1'b0, 8'h11, 8'h00);
    step(0, 1'b1, 16'hC001, 1'b0, 8'h22, 8'h00);
    step(0, 1'b1, 16'hFFFF, 1'b0, 8'h33, 8'h00);
    step(0, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h00);
    step(0, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h00);

    // Reset in the middle of the high phase of a $8000 write, request held across it.
    req_valid[0] = 1'b1;
    req_addr[0]  = 16'h8000;
    req_rw[0]    = 1'b0;
    req_wdata[0] = 8'h5A;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset(0);
    check_reset(1);
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    rst_n = 1'b1;
    align(0);
    step(0, 1'b1, 16'h8000, 1'b0, 8'h5A, 8'h00);
    random_steps(0, 30);
    step(0, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h00);

    // Fastest timing: write then read keeps the one-clk hold and releases oe with rw.
    @(negedge clk);
    align(1);
    step(1, 1'b1, 16'h8123, 1'b0, 8'h3C, 8'h00);
    step(1, 1'b1, 16'hE000, 1'b1, 8'h00, 8'h77);
    step(1, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h00);
    step(1, 1'b1, 16'hA5A5, 1'b0, 8'hC3, 8'h00);
    step(1, 1'b1, 16'h6001, 1'b1, 8'h00, 8'h5E);
    random_steps(1, 40);
    step(1, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
